// File: rtl/aes_inv_cipher_iter_if.sv
// Block-in / plaintext-out / round-key / control bundle for the iterative AES decrypt engine.
interface aes_inv_cipher_iter_if #(
   parameter int unsigned RKW = 4
);
   logic           in_valid;
   logic           in_ready;
   logic [127:0]   in_data;
   logic [RKW-1:0] rk_idx;
   logic [127:0]   rk_data;
   logic           out_valid;
   logic           out_ready;
   logic [127:0]   out_data;
   logic           busy;
   logic           flush;

   // Engine side
   modport slave (
      input  in_valid, in_data, rk_data, out_ready, flush,
      output in_ready, rk_idx, out_valid, out_data, busy
   );

   // Producer / consumer / key-store side
   modport master (
      output in_valid, in_data, rk_data, out_ready, flush,
      input  in_ready, rk_idx, out_valid, out_data, busy
   );
endinterface

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128/192/256 inverse cipher: one shared inverse-round datapath,
// NR+1 cycles per block, round keys fetched by index with zero-latency read.
module aes_inv_cipher_iter #(
   parameter int unsigned KEY_BITS = 128,
   parameter int unsigned RKW      = 4
) (
   input  logic                  clk,
   input  logic                  n_rst,
   aes_inv_cipher_iter_if.slave  bus
);

   localparam int unsigned NR = (KEY_BITS == 128) ? 10 : (KEY_BITS == 192) ? 12 : 14;
   localparam logic [RKW-1:0] RK_NR = RKW'(NR);

   // Reject unsupported key sizes and round-index widths at elaboration
   if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key
      $error("aes_inv_cipher_iter: KEY_BITS must be 128, 192 or 256");
   end
   if ((2 ** RKW) <= NR) begin : g_bad_rkw
      $error("aes_inv_cipher_iter: RKW too narrow for NR");
   end

   typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_LAST, ST_DONE} state_t;

   state_t         r_state, w_state_nxt;
   logic [127:0]   r_s, w_s_nxt;
   logic [RKW-1:0] r_r, w_r_nxt;

   logic           r_in_ready, r_out_valid, r_busy;
   logic [127:0]   r_out_data;
   logic [RKW-1:0] r_rk_idx;
   logic           w_in_ready_nxt, w_out_valid_nxt, w_busy_nxt;
   logic [127:0]   w_out_data_nxt;
   logic [RKW-1:0] w_rk_idx_nxt;

   logic [127:0]   w_sb, w_ark, w_imc;

   // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, bb;
      p  = 8'h00;
      x  = a;
      bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ x;
         x  = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         bb = {1'b0, bb[7:1]};
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (maps 0 to 0)
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] x2, x3, x12, x15, x240;
      x2   = gf_mul(a, a);
      x3   = gf_mul(x2, a);
      x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
      x15  = gf_mul(x12, x3);
      x240 = gf_mul(x15, x15);
      x240 = gf_mul(x240, x240);
      x240 = gf_mul(x240, x240);
      x240 = gf_mul(x240, x240);
      return gf_mul(gf_mul(x240, x12), x2);
   endfunction

   // Inverse S-box: undo the affine map, then invert in GF(2^8)
   function automatic logic [7:0] inv_sbox(input logic [7:0] s);
      logic [7:0] b;
      b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
      return gf_inv(b);
   endfunction

   // InvShiftRows + InvSubBytes: byte (r,c) takes the byte from column (c-r) mod 4
   for (genvar gr = 0; gr < 4; gr++) begin : g_row
      for (genvar gc = 0; gc < 4; gc++) begin : g_col
         assign w_sb[127-8*(gr+4*gc) -: 8] =
            inv_sbox(r_s[127-8*(gr+4*((gc+4-gr)%4)) -: 8]);
      end
   end

   assign w_ark = w_sb ^ bus.rk_data;

   // InvMixColumns on the key-added state, one column at a time
   for (genvar gc = 0; gc < 4; gc++) begin : g_imc
      logic [7:0] w_a0, w_a1, w_a2, w_a3;
      assign w_a0 = w_ark[127-32*gc -: 8];
      assign w_a1 = w_ark[119-32*gc -: 8];
      assign w_a2 = w_ark[111-32*gc -: 8];
      assign w_a3 = w_ark[103-32*gc -: 8];
      assign w_imc[127-32*gc -: 8] = gf_mul(w_a0, 8'h0e) ^ gf_mul(w_a1, 8'h0b) ^
                                     gf_mul(w_a2, 8'h0d) ^ gf_mul(w_a3, 8'h09);
      assign w_imc[119-32*gc -: 8] = gf_mul(w_a0, 8'h09) ^ gf_mul(w_a1, 8'h0e) ^
                                     gf_mul(w_a2, 8'h0b) ^ gf_mul(w_a3, 8'h0d);
      assign w_imc[111-32*gc -: 8] = gf_mul(w_a0, 8'h0d) ^ gf_mul(w_a1, 8'h09) ^
                                     gf_mul(w_a2, 8'h0e) ^ gf_mul(w_a3, 8'h0b);
      assign w_imc[103-32*gc -: 8] = gf_mul(w_a0, 8'h0b) ^ gf_mul(w_a1, 8'h0d) ^
                                     gf_mul(w_a2, 8'h09) ^ gf_mul(w_a3, 8'h0e);
   end

   // Next state, datapath update and next-cycle output decode
   always_comb begin
      w_state_nxt = r_state;
      w_s_nxt     = r_s;
      w_r_nxt     = r_r;
      case (r_state)
         ST_IDLE: begin
            if (bus.in_valid) begin
               w_s_nxt     = bus.in_data ^ bus.rk_data;
               w_r_nxt     = RKW'(NR - 1);
               w_state_nxt = ST_ROUND;
            end
         end
         ST_ROUND: begin
            w_s_nxt = w_imc;
            if (r_r == RKW'(1)) begin
               w_state_nxt = ST_LAST;
               w_r_nxt     = '0;
            end else begin
               w_r_nxt = r_r - RKW'(1);
            end
         end
         ST_LAST: begin
            w_s_nxt     = w_ark;
            w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            if (bus.out_ready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (bus.flush) begin
         w_state_nxt = ST_IDLE;
         w_s_nxt     = '0;
         w_r_nxt     = '0;
      end
      w_in_ready_nxt  = (w_state_nxt == ST_IDLE);
      w_busy_nxt      = (w_state_nxt == ST_ROUND) || (w_state_nxt == ST_LAST);
      w_out_valid_nxt = (w_state_nxt == ST_DONE);
      w_out_data_nxt  = (w_state_nxt == ST_DONE) ? w_s_nxt : '0;
      w_rk_idx_nxt    = (w_state_nxt == ST_IDLE) ? RK_NR : w_r_nxt;
   end

   // State register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Datapath storage and registered outputs
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_s         <= '0;
         r_r         <= '0;
         r_in_ready  <= 1'b1;
         r_busy      <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_rk_idx    <= RK_NR;
      end else begin
         r_s         <= w_s_nxt;
         r_r         <= w_r_nxt;
         r_in_ready  <= w_in_ready_nxt;
         r_busy      <= w_busy_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_out_data  <= w_out_data_nxt;
         r_rk_idx    <= w_rk_idx_nxt;
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.busy      = r_busy;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.rk_idx    = r_rk_idx;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Self-checking bench: FIPS-197 vectors plus random blocks checked against a forward-cipher model.
module tb_aes_inv_cipher_iter;

   localparam int unsigned RKW = 4;
   localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
   localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT_C2   = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;

   logic clk = 1'b0;
   logic n_rst;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]   sbox [256];
   logic [127:0] rk128 [15];
   logic [127:0] rk192 [15];
   logic [127:0] rk256 [15];

   aes_inv_cipher_iter_if #(.RKW(RKW)) m_if ();
   aes_inv_cipher_iter_if #(.RKW(RKW)) b192 ();
   aes_inv_cipher_iter_if #(.RKW(RKW)) b256 ();

   aes_inv_cipher_iter #(.KEY_BITS(128), .RKW(RKW)) dut     (.clk(clk), .n_rst(n_rst), .bus(m_if));
   aes_inv_cipher_iter #(.KEY_BITS(192), .RKW(RKW)) dut_192 (.clk(clk), .n_rst(n_rst), .bus(b192));
   aes_inv_cipher_iter #(.KEY_BITS(256), .RKW(RKW)) dut_256 (.clk(clk), .n_rst(n_rst), .bus(b256));

   // Zero-latency expanded-key stores
   assign m_if.rk_data = (m_if.rk_idx <= 4'd10) ? rk128[m_if.rk_idx] : '0;
   assign b192.rk_data = (b192.rk_idx <= 4'd12) ? rk192[b192.rk_idx] : '0;
   assign b256.rk_data = (b256.rk_idx <= 4'd14) ? rk256[b256.rk_idx] : '0;

   // ---------------- reference model (forward AES) ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, bb;
      p = 0; x = a; bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ x;
         x  = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         bb = bb >> 1;
      end
      return p;
   endfunction

   task automatic init_sbox();
      logic [7:0] inv, b;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         b = inv;
         sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subword(input logic [31:0] w);
      return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
   endfunction

   function automatic logic [127:0] round_key(input int nk, input logic [255:0] key, input int k);
      logic [31:0]  w [60];
      logic [31:0]  t;
      logic [255:0] kk;
      logic [7:0]   rc;
      kk = key; rc = 8'h01;
      for (int i = 0; i < nk; i++) begin w[i] = kk[255:224]; kk = kk << 32; end
      for (int i = nk; i < 60; i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end else if (nk > 6 && i % nk == 4) begin
            t = subword(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      return {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
   endfunction

   task automatic load_keys(input int which, input logic [255:0] key);
      for (int k = 0; k < 15; k++) begin
         case (which)
            0: rk128[k] = round_key(4, key, k);
            1: rk192[k] = round_key(6, key, k);
            default: rk256[k] = round_key(8, key, k);
         endcase
      end
   endtask

   function automatic logic [127:0] get_rk(input int which, input int k);
      case (which)
         0: return rk128[k];
         1: return rk192[k];
         default: return rk256[k];
      endcase
   endfunction

   // Forward cipher: the DUT must invert this
   function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr, input int which);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [127:0] tmp;
      tmp = pt;
      for (int i = 0; i < 16; i++) begin s[i] = tmp[127:120]; tmp = tmp << 8; end
      for (int rnd = 0; rnd <= nr; rnd++) begin
         if (rnd > 0) begin
            for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
            for (int r = 0; r < 4; r++)
               for (int c = 0; c < 4; c++) t[r+4*c] = s[r+4*((c+r)%4)];
            s = t;
            if (rnd < nr) begin
               for (int c = 0; c < 4; c++) begin
                  t[4*c]   = gmul(s[4*c],8'h02) ^ gmul(s[4*c+1],8'h03) ^ s[4*c+2] ^ s[4*c+3];
                  t[4*c+1] = s[4*c] ^ gmul(s[4*c+1],8'h02) ^ gmul(s[4*c+2],8'h03) ^ s[4*c+3];
                  t[4*c+2] = s[4*c] ^ s[4*c+1] ^ gmul(s[4*c+2],8'h02) ^ gmul(s[4*c+3],8'h03);
                  t[4*c+3] = gmul(s[4*c],8'h03) ^ s[4*c+1] ^ s[4*c+2] ^ gmul(s[4*c+3],8'h02);
               end
               s = t;
            end
         end
         tmp = get_rk(which, rnd);
         for (int i = 0; i < 16; i++) begin s[i] = s[i] ^ tmp[127:120]; tmp = tmp << 8; end
      end
      tmp = '0;
      for (int i = 0; i < 16; i++) tmp = {tmp[119:0], s[i]};
      return tmp;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- transaction driver (main 128-bit DUT) ----------------
   // Accepts one block, records rk_idx/busy errors per cycle, latency and result, then transfers it.
   task automatic run_block(input logic [127:0] ct, output int lat, output logic [127:0] res,
                            output int rkerr, output int busyerr);
      bit acc;
      lat = -1; res = '0; rkerr = 0; busyerr = 0; acc = 1'b0;
      m_if.out_ready = 1'b0;
      m_if.in_data   = ct;
      m_if.in_valid  = 1'b1;
      for (int n = 0; n < 50 && !acc; n++) begin
         acc = m_if.in_ready;
         @(negedge clk);
      end
      m_if.in_valid = 1'b0;
      if (acc) begin
         for (int c = 1; c <= 60; c++) begin
            if (m_if.out_valid === 1'b1) begin lat = c; res = m_if.out_data; break; end
            if (m_if.rk_idx !== 4'(10 - c)) rkerr++;
            if (m_if.busy !== 1'b1) busyerr++;
            @(negedge clk);
         end
         if (lat > 0) begin
            m_if.out_ready = 1'b1;
            @(negedge clk);
            m_if.out_ready = 1'b0;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      n_checks++; if (m_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", m_if.in_ready); end
      n_checks++; if (m_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", m_if.out_valid); end
      n_checks++; if (m_if.out_data !== 128'h0) begin n_fail++; $display("FAIL reset_out_data got %h exp 0", m_if.out_data); end
      n_checks++; if (m_if.rk_idx !== 4'd10) begin n_fail++; $display("FAIL reset_rk_idx got %0d exp 10", m_if.rk_idx); end
      n_checks++; if (m_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", m_if.busy); end
      n_checks++; if (b256.rk_idx !== 4'd14) begin n_fail++; $display("FAIL reset_rk_idx_256 got %0d exp 14", b256.rk_idx); end
   endtask

   task automatic test_fips128();
      int lat, rkerr, busyerr;
      logic [127:0] res;
      load_keys(0, K128);
      run_block(CT_C1, lat, res, rkerr, busyerr);
      n_checks++; if (lat != 11) begin n_fail++; $display("FAIL c1_latency got %0d exp 11", lat); end
      n_checks++; if (res !== PT_FIPS) begin n_fail++; $display("FAIL c1_data got %h exp %h", res, PT_FIPS); end
      n_checks++; if (rkerr != 0) begin n_fail++; $display("FAIL c1_rk_idx_seq got %0d bad cycles exp 0", rkerr); end
      n_checks++; if (busyerr != 0) begin n_fail++; $display("FAIL c1_busy got %0d bad cycles exp 0", busyerr); end
      n_checks++; if ({m_if.in_ready, m_if.out_valid, m_if.out_data} !== {2'b10, 128'h0}) begin
         n_fail++; $display("FAIL c1_after_transfer got rdy=%b vld=%b data=%h exp rdy=1 vld=0 data=0",
                            m_if.in_ready, m_if.out_valid, m_if.out_data); end
   endtask

   task automatic test_key_sizes();
      int lat192 = -1, lat256 = -1;
      logic [127:0] res192 = '0, res256 = '0;
      load_keys(1, K192);
      load_keys(2, K256);
      b192.in_data = CT_C2; b192.in_valid = 1'b1;
      b256.in_data = CT_C3; b256.in_valid = 1'b1;
      @(negedge clk);
      b192.in_valid = 1'b0; b256.in_valid = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (b192.out_valid === 1'b1 && lat192 < 0) begin lat192 = c; res192 = b192.out_data; end
         if (b256.out_valid === 1'b1 && lat256 < 0) begin lat256 = c; res256 = b256.out_data; end
         @(negedge clk);
      end
      n_checks++; if (lat192 != 13) begin n_fail++; $display("FAIL c2_latency got %0d exp 13", lat192); end
      n_checks++; if (res192 !== PT_FIPS) begin n_fail++; $display("FAIL c2_data got %h exp %h", res192, PT_FIPS); end
      n_checks++; if (lat256 != 15) begin n_fail++; $display("FAIL c3_latency got %0d exp 15", lat256); end
      n_checks++; if (res256 !== PT_FIPS) begin n_fail++; $display("FAIL c3_data got %h exp %h", res256, PT_FIPS); end
   endtask

   task automatic test_backpressure();
      int err, n;
      logic [127:0] pt2, ct2;
      load_keys(0, K128);
      pt2 = rand128();
      ct2 = encrypt(pt2, 10, 0);
      m_if.out_ready = 1'b0;
      m_if.in_data = CT_C1; m_if.in_valid = 1'b1;
      n = 0; while (m_if.in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
      m_if.in_data = ct2;
      n = 0; while (m_if.out_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      n_checks++; if (m_if.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid_timeout got %b exp 1", m_if.out_valid); end
      err = 0;
      for (int i = 0; i < 20; i++) begin
         if (m_if.out_valid !== 1'b1 || m_if.out_data !== PT_FIPS || m_if.in_ready !== 1'b0 || m_if.busy !== 1'b0) err++;
         @(negedge clk);
      end
      n_checks++; if (err != 0) begin n_fail++; $display("FAIL bp_hold got %0d unstable cycles exp 0", err); end
      m_if.out_ready = 1'b1;
      @(negedge clk);
      m_if.out_ready = 1'b0;
      n_checks++; if ({m_if.busy, m_if.in_ready, m_if.out_valid} !== 3'b010) begin
         n_fail++; $display("FAIL bp_idle_gap got busy/rdy/vld=%b exp 010", {m_if.busy, m_if.in_ready, m_if.out_valid}); end
      @(negedge clk);
      m_if.in_valid = 1'b0;
      n_checks++; if ({m_if.busy, m_if.rk_idx} !== {1'b1, 4'd9}) begin
         n_fail++; $display("FAIL bp_second_accept got busy=%b rk_idx=%0d exp busy=1 rk_idx=9", m_if.busy, m_if.rk_idx); end
      n = 0; while (m_if.out_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      n_checks++; if (m_if.out_data !== pt2) begin n_fail++; $display("FAIL bp_second_data got %h exp %h", m_if.out_data, pt2); end
      m_if.out_ready = 1'b1;
      @(negedge clk);
      m_if.out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [127:0] pt [8];
      logic [127:0] ct [8];
      int acc_cyc [8];
      int na = 0, nout = 0;
      load_keys(0, {rand128(), 128'h0});
      for (int i = 0; i < 8; i++) begin pt[i] = rand128(); ct[i] = encrypt(pt[i], 10, 0); end
      m_if.out_ready = 1'b1;
      for (int cyc = 0; cyc < 200 && nout < 8; cyc++) begin
         m_if.in_valid = (na < 8);
         if (na < 8) m_if.in_data = ct[na];
         if (m_if.out_valid === 1'b1) begin
            n_checks++;
            if (m_if.out_data !== pt[nout]) begin
               n_fail++; $display("FAIL b2b_data[%0d] got %h exp %h", nout, m_if.out_data, pt[nout]); end
            nout++;
         end
         if (m_if.in_ready === 1'b1 && na < 8) begin acc_cyc[na] = cyc; na++; end
         @(negedge clk);
      end
      m_if.in_valid = 1'b0;
      m_if.out_ready = 1'b0;
      n_checks++; if (nout != 8) begin n_fail++; $display("FAIL b2b_count got %0d exp 8", nout); end
      for (int i = 1; i < na; i++) begin
         n_checks++;
         if (acc_cyc[i] - acc_cyc[i-1] != 12) begin
            n_fail++; $display("FAIL b2b_spacing[%0d] got %0d exp 12", i, acc_cyc[i] - acc_cyc[i-1]); end
      end
   endtask

   task automatic test_flush();
      int n, pulses, lat, rkerr, busyerr;
      logic [127:0] pt, res;
      load_keys(0, K128);
      m_if.in_data = CT_C1; m_if.in_valid = 1'b1;
      n = 0; while (m_if.in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
      m_if.in_valid = 1'b0;
      n = 0; while (m_if.rk_idx !== 4'd5 && n < 20) begin @(negedge clk); n++; end
      m_if.flush = 1'b1;
      @(negedge clk);
      m_if.flush = 1'b0;
      n_checks++; if ({m_if.busy, m_if.in_ready, m_if.out_valid, m_if.rk_idx} !== {3'b010, 4'd10}) begin
         n_fail++; $display("FAIL flush_idle got busy/rdy/vld=%b rk_idx=%0d exp 010 rk_idx=10",
                            {m_if.busy, m_if.in_ready, m_if.out_valid}, m_if.rk_idx); end
      pulses = 0;
      for (int i = 0; i < 20; i++) begin if (m_if.out_valid !== 1'b0) pulses++; @(negedge clk); end
      n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL flush_no_output got %0d valid cycles exp 0", pulses); end
      m_if.in_valid = 1'b1; m_if.flush = 1'b1;
      @(negedge clk);
      m_if.in_valid = 1'b0; m_if.flush = 1'b0;
      n_checks++; if ({m_if.busy, m_if.in_ready} !== 2'b01) begin
         n_fail++; $display("FAIL flush_over_valid got busy/rdy=%b exp 01", {m_if.busy, m_if.in_ready}); end
      pt = rand128();
      run_block(encrypt(pt, 10, 0), lat, res, rkerr, busyerr);
      n_checks++; if (res !== pt || lat != 11) begin
         n_fail++; $display("FAIL flush_next_block got %h lat %0d exp %h lat 11", res, lat, pt); end
   endtask

   task automatic test_async_reset();
      int n, pulses, lat, rkerr, busyerr;
      logic [127:0] res;
      load_keys(0, K128);
      m_if.in_data = CT_C1; m_if.in_valid = 1'b1;
      n = 0; while (m_if.in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
      m_if.in_valid = 1'b0;
      n = 0; while (m_if.rk_idx !== 4'd6 && n < 20) begin @(negedge clk); n++; end
      #2 n_rst = 1'b0;
      #1;
      n_checks++; if ({m_if.in_ready, m_if.out_valid, m_if.busy, m_if.rk_idx, m_if.out_data} !== {3'b100, 4'd10, 128'h0}) begin
         n_fail++; $display("FAIL async_reset got rdy/vld/busy=%b rk_idx=%0d data=%h exp 100 10 0",
                            {m_if.in_ready, m_if.out_valid, m_if.busy}, m_if.rk_idx, m_if.out_data); end
      @(negedge clk);
      n_rst = 1'b1;
      pulses = 0;
      for (int i = 0; i < 15; i++) begin if (m_if.out_valid !== 1'b0 || m_if.busy !== 1'b0) pulses++; @(negedge clk); end
      n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL reset_no_partial got %0d active cycles exp 0", pulses); end
      run_block(CT_C1, lat, res, rkerr, busyerr);
      n_checks++; if (res !== PT_FIPS || lat != 11) begin
         n_fail++; $display("FAIL reset_then_c1 got %h lat %0d exp %h lat 11", res, lat, PT_FIPS); end
   endtask

   initial begin
      n_rst = 1'b0;
      m_if.in_valid = 1'b0; m_if.in_data = '0; m_if.out_ready = 1'b0; m_if.flush = 1'b0;
      b192.in_valid = 1'b0; b192.in_data = '0; b192.out_ready = 1'b1; b192.flush = 1'b0;
      b256.in_valid = 1'b0; b256.in_data = '0; b256.out_ready = 1'b1; b256.flush = 1'b0;
      init_sbox();
      load_keys(0, K128);
      load_keys(1, K192);
      load_keys(2, K256);
      @(negedge clk);
      @(negedge clk);
      test_reset();
      n_rst = 1'b1;
      @(negedge clk);
      test_fips128();
      test_key_sizes();
      test_backpressure();
      test_back_to_back();
      test_flush();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired: bench did not complete");
      $fatal(1);
   end

endmodule
